// File: rtl/cart_pkg.sv
// Shared constants for the cartridge ROM download path (FSM encoding, header size,
// Game Gear index).
package cart_pkg;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitByte = 2'd1;
  localparam logic [1:0] StWaitAck  = 2'd2;
  localparam logic [1:0] StFinish   = 2'd3;

  localparam int unsigned HDR_BYTES = 512;

  localparam logic [1:0] GG_INDEX = 2'd2;

endpackage

// File: rtl/cart_loader.sv
// Bridges the data_io byte stream to toggle-handshake SDRAM writes and latches cart geometry.
// Define CART_SUM_EN to add the cart_sum output (16-bit payload byte sum).
module cart_loader #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned CART_W    = 22,
  parameter int unsigned HDR_BYTES = cart_pkg::HDR_BYTES
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        din,
  output logic              we,
  input  logic              we_ack,
  output logic [CART_W-1:0] cart_mask,
  output logic              romhdr,
  output logic              gg,
  output logic              cart_valid,
  output logic              overflow
`ifdef CART_SUM_EN
  ,
  output logic [15:0]       cart_sum
`endif
);

  import cart_pkg::*;

  localparam int unsigned     HdrBit    = $clog2(HDR_BYTES);
  localparam logic [ADDR_W:0] CntOne    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CartLimit = CntOne << CART_W;
  localparam logic [ADDR_W:0] HdrCnt    = (ADDR_W + 1)'(HDR_BYTES);

  logic [1:0]        state_q, state_d;
  logic              dl_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [CART_W-1:0] mask_all_q, mask_all_d;
  logic [CART_W-1:0] mask_off_q, mask_off_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        din_q, din_d;
  logic              we_q, we_d;
  logic [CART_W-1:0] cart_mask_q, cart_mask_d;
  logic              romhdr_q, romhdr_d;
  logic              gg_q, gg_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
`ifdef CART_SUM_EN
  logic [15:0]       sum_all_q, sum_all_d;
  logic [15:0]       sum_off_q, sum_off_d;
  logic [15:0]       cart_sum_q, cart_sum_d;
`endif

  logic              dl_rise;
  logic              restart;
  logic [CART_W-1:0] cnt_off;
  logic              unused_idx;

  assign dl_rise    = ioctl_download & ~dl_q;
  // A rising edge while still collecting bytes aborts and restarts the download.
  assign restart    = dl_rise & ((state_q == StIdle) | (state_q == StWaitByte));
  assign cnt_off    = CART_W'(cnt_q - HdrCnt);
  assign unused_idx = ^ioctl_index[5:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_all_d  = mask_all_q;
    mask_off_d  = mask_off_q;
    wait_d      = wait_q;
    waddr_d     = waddr_q;
    din_d       = din_q;
    we_d        = we_q;
    cart_mask_d = cart_mask_q;
    romhdr_d    = romhdr_q;
    gg_d        = gg_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
`ifdef CART_SUM_EN
    sum_all_d   = sum_all_q;
    sum_off_d   = sum_off_q;
    cart_sum_d  = cart_sum_q;
`endif

    if (restart) begin
      state_d     = StWaitByte;
      cnt_d       = '0;
      mask_all_d  = '0;
      mask_off_d  = '0;
      cart_mask_d = '0;
      romhdr_d    = 1'b0;
      valid_d     = 1'b0;
      ovf_d       = 1'b0;
      gg_d        = (ioctl_index[7:6] == GG_INDEX);
`ifdef CART_SUM_EN
      sum_all_d   = '0;
      sum_off_d   = '0;
      cart_sum_d  = '0;
`endif
    end else begin
      case (state_q)
        StWaitByte: begin
          if (ioctl_wr) begin
            din_d   = ioctl_dout;
            waddr_d = cnt_q[ADDR_W-1:0];
            if (cnt_q < CartLimit) begin
              we_d    = ~we_q;
              wait_d  = 1'b1;
              state_d = StWaitAck;
            end else begin
              // Beyond the cartridge window: count the byte but never write it.
              ovf_d = 1'b1;
              cnt_d = cnt_q + CntOne;
            end
          end else if (!ioctl_download) begin
            state_d = StFinish;
          end
        end

        StWaitAck: begin
          if (we_ack == we_q) begin
            wait_d     = 1'b0;
            mask_all_d = mask_all_q | cnt_q[CART_W-1:0];
            if (cnt_q >= HdrCnt) begin
              mask_off_d = mask_off_q | cnt_off;
            end
`ifdef CART_SUM_EN
            sum_all_d = sum_all_q + 16'(din_q);
            if (cnt_q >= HdrCnt) begin
              sum_off_d = sum_off_q + 16'(din_q);
            end
`endif
            cnt_d   = cnt_q + CntOne;
            state_d = StWaitByte;
          end
        end

        StFinish: begin
          romhdr_d    = cnt_q[HdrBit];
          cart_mask_d = cnt_q[HdrBit] ? mask_off_q : mask_all_q;
          valid_d     = 1'b1;
`ifdef CART_SUM_EN
          cart_sum_d  = cnt_q[HdrBit] ? sum_off_q : sum_all_q;
`endif
          state_d     = StIdle;
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      cnt_q       <= '0;
      mask_all_q  <= '0;
      mask_off_q  <= '0;
      wait_q      <= 1'b0;
      waddr_q     <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      cart_mask_q <= '0;
      romhdr_q    <= 1'b0;
      gg_q        <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef CART_SUM_EN
      sum_all_q   <= '0;
      sum_off_q   <= '0;
      cart_sum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      cnt_q       <= cnt_d;
      mask_all_q  <= mask_all_d;
      mask_off_q  <= mask_off_d;
      wait_q      <= wait_d;
      waddr_q     <= waddr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      cart_mask_q <= cart_mask_d;
      romhdr_q    <= romhdr_d;
      gg_q        <= gg_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
`ifdef CART_SUM_EN
      sum_all_q   <= sum_all_d;
      sum_off_q   <= sum_off_d;
      cart_sum_q  <= cart_sum_d;
`endif
    end
  end

  assign ioctl_wait = wait_q;
  assign waddr      = waddr_q;
  assign din        = din_q;
  assign we         = we_q;
  assign cart_mask  = cart_mask_q;
  assign romhdr     = romhdr_q;
  assign gg         = gg_q;
  assign cart_valid = valid_q;
  assign overflow   = ovf_q;
`ifdef CART_SUM_EN
  assign cart_sum   = cart_sum_q;
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: random downloads against a file-level reference model.
// Uses a reduced cartridge window (CART_W=11) so overflow is reachable in a short run.
module tb_cart_loader;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned CART_W    = 11;
  localparam int unsigned HDR       = 512;
  localparam int          CartBytes = 1 << CART_W;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        din;
  logic              we;
  logic              we_ack;
  logic [CART_W-1:0] cart_mask;
  logic              romhdr;
  logic              gg;
  logic              cart_valid;
  logic              overflow;
`ifdef CART_SUM_EN
  logic [15:0]       cart_sum;
`endif

  cart_loader #(
    .ADDR_W    (ADDR_W),
    .CART_W    (CART_W),
    .HDR_BYTES (HDR)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .waddr          (waddr),
    .din            (din),
    .we             (we),
    .we_ack         (we_ack),
    .cart_mask      (cart_mask),
    .romhdr         (romhdr),
    .gg             (gg),
    .cart_valid     (cart_valid),
    .overflow       (overflow)
`ifdef CART_SUM_EN
    ,
    .cart_sum       (cart_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    logic [CART_W-1:0] mask;
    logic              hdr;
    logic              gg;
    logic              ovf;
    logic [15:0]       sum;
  } res_t;

  wr_t         wr_q[$];
  res_t        res_q[$];
  logic [7:0]  file_data[$];
  int          checks = 0;
  int          errors = 0;
  int          results_seen = 0;
  int          ack_delay = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // OR of 0..n-1, i.e. the smallest all-ones mask covering n addresses.
  function automatic int span_mask(input int n);
    if (n <= 1) return 0;
    return (1 << $clog2(n)) - 1;
  endfunction

  // File-level expectation: header when the byte count has bit 512 set, payload addressed
  // relative to the header, bytes past the cartridge window dropped.
  function automatic res_t model(input int n, input logic [7:0] idx);
    res_t        r;
    int          accepted;
    int          m;
    logic [15:0] s_all;
    logic [15:0] s_off;
    accepted = (n < CartBytes) ? n : CartBytes;
    r.hdr    = ((n / HDR) % 2) == 1;
    m        = r.hdr ? span_mask(accepted - HDR) : span_mask(accepted);
    r.mask   = m[CART_W-1:0];
    r.gg     = (idx[7:6] == 2'd2);
    r.ovf    = (n > CartBytes);
    s_all    = '0;
    s_off    = '0;
    for (int i = 0; i < accepted; i++) begin
      s_all = s_all + 16'(file_data[i]);
      if (i >= HDR) s_off = s_off + 16'(file_data[i]);
    end
    r.sum = r.hdr ? s_off : s_all;
    return r;
  endfunction

  // SDRAM controller: acknowledges a new toggle after ack_delay cycles.
  initial begin : sdram_model
    int left;
    left   = 0;
    we_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        we_ack = 1'b0;
        left   = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) we_ack = ~we_ack;
      end else if (we !== we_ack) begin
        left = ack_delay;
      end
    end
  end

  initial begin : monitor
    logic prev_we;
    logic prev_valid;
    wr_t  e;
    res_t r;
    prev_we    = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_we    = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (we !== prev_we) begin
          prev_we = we;
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: waddr 0x%0h din 0x%0h, no write expected",
                     waddr, din);
          end else begin
            e = wr_q.pop_front();
            check("waddr", 64'(waddr), 64'(e.addr));
            check("din", 64'(din), 64'(e.data));
          end
        end
        if (cart_valid && !prev_valid) begin
          if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: cart_valid 1, expected 0");
          end else begin
            r = res_q.pop_front();
            check("cart_mask", 64'(cart_mask), 64'(r.mask));
            check("romhdr", 64'(romhdr), 64'(r.hdr));
            check("gg", 64'(gg), 64'(r.gg));
            check("overflow", 64'(overflow), 64'(r.ovf));
`ifdef CART_SUM_EN
            check("cart_sum", 64'(cart_sum), 64'(r.sum));
`endif
          end
          results_seen++;
        end
        prev_valid = cart_valid;
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

  task automatic expect_write(input int i, input logic [7:0] b);
    wr_t e;
    e.addr = i[ADDR_W-1:0];
    e.data = b;
    wr_q.push_back(e);
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input int d);
    int high;
    ack_delay = d;
    if (i < CartBytes) expect_write(i, b);
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
    high     = 0;
    @(negedge clk_sys);
    while (ioctl_wait === 1'b1 && high < 64) begin
      high++;
      @(negedge clk_sys);
    end
    // Stall spans the whole ack wait: the d-cycle controller latency plus the ack cycle.
    if (i < CartBytes) check("wait_cycles", 64'(high), 64'(d + 1));
    else check("wait_dropped", 64'(high), 64'(0));
  endtask

  task automatic wait_result(input int seen);
    int k;
    k = 0;
    while (results_seen == seen && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    check("result_arrived", 64'(results_seen), 64'(seen + 1));
    check("writes_drained", 64'(wr_q.size()), 64'(0));
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic fill_file(input int n);
    file_data.delete();
    for (int i = 0; i < n; i++) file_data.push_back(8'($urandom));
  endtask

  task automatic run_download(input int n, input logic [7:0] idx, input int dmin,
                              input int dmax);
    int seen;
    fill_file(n);
    res_q.push_back(model(n, idx));
    seen = results_seen;
    @(posedge clk_sys);
    #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) send_byte(i, file_data[i], int'($urandom_range(dmax, dmin)));
    @(posedge clk_sys);
    #1;
    ioctl_download = 1'b0;
    wait_result(seen);
  endtask

  initial begin : stimulus
    int seen;
    int high;
    int k;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    ioctl_index    = 8'h00;
    #3;
    check("reset_outputs",
          64'({ioctl_wait, waddr, din, we, cart_mask, romhdr, gg, cart_valid, overflow}), 64'(0));
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;

    run_download(CartBytes, 8'h00, 3, 3);
    run_download(HDR + 1024, 8'h00, 1, 4);
    run_download(1024, 8'h80, 1, 4);
    run_download(0, 8'h40, 1, 1);

    // Download drops while the last write is still waiting for its ack.
    fill_file(257);
    res_q.push_back(model(257, 8'h00));
    seen = results_seen;
    @(posedge clk_sys);
    #1;
    ioctl_index    = 8'h00;
    ioctl_download = 1'b1;
    for (int i = 0; i < 256; i++) send_byte(i, file_data[i], 2);
    expect_write(256, file_data[256]);
    ack_delay = 10;
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b1;
    ioctl_dout = file_data[256];
    @(posedge clk_sys);
    #1;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    high           = 0;
    @(negedge clk_sys);
    while (ioctl_wait === 1'b1 && high < 64) begin
      high++;
      @(negedge clk_sys);
    end
    check("drop_wait_cycles", 64'(high), 64'(11));
    k = 0;
    while (cart_valid !== 1'b1 && k < 10) begin
      @(negedge clk_sys);
      k++;
    end
    check("drop_valid_latency", 64'(k), 64'(2));
    wait_result(seen);

    // Reset asserted while byte 100 is in flight.
    fill_file(300);
    @(posedge clk_sys);
    #1;
    ioctl_index    = 8'h80;
    ioctl_download = 1'b1;
    for (int i = 0; i < 100; i++) send_byte(i, file_data[i], 2);
    expect_write(100, file_data[100]);
    ack_delay = 5;
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b1;
    ioctl_dout = file_data[100];
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset",
          64'({ioctl_wait, waddr, din, we, cart_mask, romhdr, gg, cart_valid, overflow}), 64'(0));
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    check("writes_after_reset", 64'(wr_q.size()), 64'(0));
    run_download(300, 8'hC0, 1, 3);

    run_download(CartBytes + 4, 8'h00, 1, 1);
    run_download(int'($urandom_range(CartBytes + 50, 1)), 8'($urandom), 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between data_io and the sdram controller on the cartridge ROM path.
- Takes the ioctl byte stream and issues one toggle-handshake SDRAM write per byte, throttling data_io through ioctl_wait.
- At download end it latches the cartridge geometry used by the read path: 512-byte header flag, payload-relative address mask, and Game Gear select.

Parameters:
- ADDR_W, 24, SDRAM byte write address width.
- CART_W, 22, cartridge address width; bytes at or beyond 2^CART_W are dropped.
- HDR_BYTES, 512, copier-header size.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  high for the whole download.
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout valid.
- ioctl_dout  in  8  download byte.
- ioctl_index  in  8  file-type index; [7:6]==2 means Game Gear.
- ioctl_wait  out  1  stall request to data_io.
- waddr  out  ADDR_W  SDRAM write address.
- din  out  8  SDRAM write data.
- we  out  1  write request toggle.
- we_ack  in  1  SDRAM acknowledge toggle; the write is done when we_ack==we.
- cart_mask  out  CART_W  payload address mask.
- romhdr  out  1  file carries a 512-byte header.
- gg  out  1  Game Gear cartridge.
- cart_valid  out  1  a download has completed.
- overflow  out  1  at least one byte was dropped.

Behaviour:
- Reset values: all outputs 0, including we. State = IDLE.
- Internal state: byte counter cnt[ADDR_W:0], mask_all, mask_off.
- States:
  - IDLE: on ioctl_download rising edge, clear cnt, both masks, cart_valid, romhdr, overflow and cart_mask. Latch gg = (ioctl_index[7:6]==2). Go to WAIT_BYTE.
  - WAIT_BYTE: on ioctl_wr, register din=ioctl_dout and waddr=cnt, then do one of the following.
    - If cnt < 2^CART_W: toggle we, set ioctl_wait=1 (visible the cycle after ioctl_wr), go to WAIT_ACK.
    - Otherwise: set overflow, do not toggle we, increment cnt, leave ioctl_wait at 0, stay in WAIT_BYTE.
    - If ioctl_download is low and no ioctl_wr is pending, go to FINISH.
  - WAIT_ACK: when we_ack==we, perform the following in one cycle, then return to WAIT_BYTE.
    - ioctl_wait=0.
    - mask_all |= cnt[CART_W-1:0].
    - If cnt >= HDR_BYTES: mask_off |= (cnt-HDR_BYTES)[CART_W-1:0].
    - cnt += 1.
  - FINISH: one cycle, then go to IDLE.
    - romhdr = cnt[9].
    - cart_mask = romhdr ? mask_off : mask_all.
    - cart_valid = 1.
- Handshake:
  - At most one outstanding write.
  - we toggles exactly once per accepted byte.
  - ioctl_wait stays high for the whole of WAIT_ACK.
  - An ioctl_wr arriving during WAIT_ACK is a protocol error: ignored, no state change.
- Boundaries:
  - Download falls while in WAIT_ACK: the pending write completes, then FINISH runs.
  - Zero-byte download: romhdr=0, cart_mask=0, cart_valid=1.
  - Ack already equal on the first WAIT_ACK cycle: cannot happen, because we has just toggled.
  - New download rising edge while in WAIT_BYTE (abort then restart): restart as from IDLE; cart_valid stays 0.
  - reset asserted mid-write: everything clears immediately. The sdram controller's in-flight toggle is discarded. After reset, we and we_ack may disagree until the controller is also reset; both share the top-level reset.

Optional Feature:
- CART_SUM_EN defined:
  - Adds output cart_sum[15:0]: running 16-bit wraparound sum of accepted payload bytes (cnt >= HDR_BYTES when romhdr is finally 1).
  - Implemented as two accumulators (all bytes, post-header bytes), selected in FINISH.
  - Cleared on download start and on reset.
- Undefined: port absent; no accumulators.

Decomposition:
- Package cart_pkg:
  - State enum {IDLE, WAIT_BYTE, WAIT_ACK, FINISH}.
  - HDR_BYTES constant.
  - GG_INDEX constant = 2'd2.
- No sub-module; single always_ff plus output assigns.

Test Plan:
- 32768-byte SMS file (index 0x00), sdram acks after 3 cycles:
  - 32768 we toggles; waddr 0..0x7FFF.
  - cart_mask=0x007FFF, romhdr=0, gg=0, cart_valid=1.
- 33280-byte file (512 header + 32K):
  - romhdr=1, cart_mask=0x007FFF (not 0x00FFFF).
- GG file (index 0x80), 256 KB:
  - gg=1, cart_mask=0x03FFFF.
  - ioctl_wait high exactly from the cycle after each ioctl_wr until ack.
- Download drops while in WAIT_ACK, with ack delayed 10 cycles:
  - write completes, cnt counts the byte, cart_valid rises one cycle after FINISH.
- reset pulse mid-transfer at byte 100:
  - all outputs 0 asynchronously.
  - New download restarts at waddr=0.
- 2^22+4 bytes:
  - last 4 bytes dropped, no toggles, overflow=1, ioctl_wait stays 0 for those bytes.
